// File: rtl/rpi_link_pkg.sv
// Shared types and constants for the Raspberry Pi instruction link:
// loader FSM states, status-byte layout and the debug view of the loader.
package rpi_link_pkg;

  localparam int INST_BYTES = 10;

  localparam int ST_BUSY = 7;
  localparam int ST_REJ  = 6;
  localparam int ST_FERR = 5;
  localparam int ST_OVR  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WAIT_IDLE,
    S_CHECK,
    S_WAIT_START
  } state_t;

  typedef struct packed {
    state_t     state;
    logic       sclk;
    logic       cs_n;
    logic [6:0] bit_cnt;
  } dbg_t;

  function automatic logic [7:0] status_byte(input logic busy, input logic rej,
                                             input logic ferr, input logic ovr);
    logic [7:0] s;
    s          = '0;
    s[ST_BUSY] = busy;
    s[ST_REJ]  = rej;
    s[ST_FERR] = ferr;
    s[ST_OVR]  = ovr;
    return s;
  endfunction

endpackage

// File: rtl/rpi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
module rpi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{INIT}};
      r_prev <= INIT;
    end else begin
      r_sync <= (r_sync << 1) | STAGES'(i_d);
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/rpi_inst_loader.sv
// SPI-slave instruction loader: assembles one frame from the Pi, then hands it
// to the task manager and reports the outcome as a status byte on MISO.
module rpi_inst_loader
  import rpi_link_pkg::*;
#(
  parameter int INST_BITS     = INST_BYTES * 8,
  parameter int SYNC_STAGES   = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_sclk,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [INST_BITS-1:0] RPi_inst,
  output logic                 execute_task,
  input  logic                 inst_valid,
  input  logic                 idle,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 inst_reject,
  output logic                 overrun,
  output dbg_t                 dbg
);

  localparam int TW = $clog2(START_TIMEOUT + 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_shift;
  logic [7:0] w_status;
  logic [INST_BITS-1:0] w_shadow_nx;
  logic [6:0] w_bit_cnt_nx;

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [INST_BITS-1:0]   r_shadow, r_inst;
  logic [6:0]             r_bit_cnt;
  logic [7:0]             r_miso_sr;
  logic                   r_miso;
  state_t                 r_state;
  logic                   r_busy, r_ferr, r_rej, r_ovr, r_exec, r_drop;
  logic [TW-1:0]          r_tmo;

  rpi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(spi_sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  rpi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_d(spi_cs_n),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  // cs_n counts as low in its rise cycle so a coincident sclk rise still shifts.
  assign w_shift  = w_sclk_rise && (!w_cs_lvl || w_cs_rise);
  assign w_status = status_byte(r_busy, r_rej, r_ferr, r_ovr);

  always_comb begin
    w_shadow_nx  = r_shadow;
    w_bit_cnt_nx = r_bit_cnt;
    if (w_shift) begin
      w_shadow_nx = {r_shadow[INST_BITS-2:0], r_mosi_sync[SYNC_STAGES-1]};
      if (r_bit_cnt != 7'd127) w_bit_cnt_nx = r_bit_cnt + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_sync <= '0;
      r_shadow    <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_miso_sr   <= '0;
    end else begin
      r_mosi_sync <= (r_mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
      r_shadow    <= w_shadow_nx;
      r_bit_cnt   <= w_cs_fall ? 7'd0 : w_bit_cnt_nx;
      if (w_cs_fall) begin
        r_miso    <= w_status[7];
        r_miso_sr <= {w_status[6:0], 1'b0};
      end else if (w_sclk_fall && !w_cs_lvl) begin
        r_miso    <= r_miso_sr[7];
        r_miso_sr <= {r_miso_sr[6:0], 1'b0};
      end
    end
  end

  // Issue handshake: execute_task is a one-cycle request raised only when idle
  // was seen high and inst_valid high one cycle later; idle falling afterwards
  // is the acknowledge, and no acknowledge within START_TIMEOUT is a reject.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_inst  <= '0;
      r_exec  <= 1'b0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
      r_rej   <= 1'b0;
      r_ovr   <= 1'b0;
      r_drop  <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_exec <= 1'b0;
      if (w_cs_fall && r_busy) begin
        r_drop <= 1'b1;
      end else if (w_cs_rise && r_drop) begin
        r_drop <= 1'b0;
        r_ovr  <= 1'b1;
      end
      case (r_state)
        S_IDLE: if (w_cs_fall) r_state <= S_RECV;
        S_RECV: begin
          if (w_cs_rise) begin
            if (w_bit_cnt_nx == 7'(INST_BITS)) begin
              r_inst  <= w_shadow_nx;
              r_ferr  <= 1'b0;
              r_rej   <= 1'b0;
              r_ovr   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_WAIT_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_WAIT_IDLE: if (idle) r_state <= S_CHECK;
        S_CHECK: begin
          if (inst_valid) begin
            r_exec  <= 1'b1;
            r_tmo   <= '0;
            r_state <= S_WAIT_START;
          end else begin
            r_rej   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT_START: begin
          if (!idle) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_tmo == TW'(START_TIMEOUT - 1)) begin
            r_rej   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spi_miso     = r_miso;
  assign RPi_inst     = r_inst;
  assign execute_task = r_exec;
  assign busy         = r_busy;
  assign frame_err    = r_ferr;
  assign inst_reject  = r_rej;
  assign overrun      = r_ovr;
  assign dbg          = '{state: r_state, sclk: w_sclk_lvl, cs_n: w_cs_lvl, bit_cnt: r_bit_cnt};

endmodule

// File: doc/rpi_inst_loader.md
Name: rpi_inst_loader

Overview:
Upstream feeder for the task manager. It receives one 80-bit instruction frame from the Raspberry Pi over a mode-0 SPI slave link, which is oversampled on clk. It presents the frame on RPi_inst and issues a single-cycle execute_task once the task manager is idle and reports the instruction valid. Every frame ends in one of three outcomes, accepted, rejected or errored, and the outcome is reported back to the Pi as a status byte on MISO.

Parameters:
INST_BITS, 80, instruction frame length in bits; must be a multiple of 8.
SYNC_STAGES, 2, flop depth of the synchronizers on sclk, cs_n and mosi.
START_TIMEOUT, 16, clk cycles allowed for idle to fall after execute_task.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
spi_sclk  in  1  SPI clock from the Pi, asynchronous to clk
spi_cs_n  in  1  SPI chip select, active-low
spi_mosi  in  1  SPI data from the Pi, MSB first
spi_miso  out  1  status byte to the Pi, MSB first
RPi_inst  out  INST_BITS  assembled instruction; byte 0 of the frame lands in [79:72]
execute_task  out  1  one-cycle start request to the task manager
inst_valid  in  1  task manager's validity verdict on RPi_inst
idle  in  1  task manager idle flag
busy  out  1  high from frame end until the issue sequence resolves
frame_err  out  1  sticky: last frame had a bit count other than INST_BITS
inst_reject  out  1  sticky: last complete frame had inst_valid low
overrun  out  1  sticky: a frame arrived while busy and was dropped

Behaviour:
- Reset values: RPi_inst=0, execute_task=0, busy=0, all sticky flags=0, spi_miso=0, FSM=S_IDLE, bit counter=0. Reset mid-frame or mid-issue discards all progress.
- Input sync: each SPI input passes through SYNC_STAGES flops. sclk and cs_n edges are detected on the synchronized copies.
- Shifting:
  - On each synchronized sclk rise with cs_n low, mosi shifts into a shadow register and the 7-bit bit counter increments, saturating at 127.
  - On each sclk fall, spi_miso shifts out the next bit of the status byte.
  - The status byte is {busy, inst_reject, frame_err, overrun, 4'b0}, snapshotted on cs_n fall. Bytes after the first return 0.
- FSM:
  - S_IDLE: on cs_n fall, clear the bit counter, load the MISO snapshot, go to S_RECV.
  - S_RECV: on cs_n rise:
    - bit count == INST_BITS: copy shadow to RPi_inst; clear frame_err, inst_reject and overrun; set busy; go to S_WAIT_IDLE.
    - otherwise: set frame_err; RPi_inst unchanged; go to S_IDLE.
  - S_WAIT_IDLE: hold while idle==0; there is no timeout here. When idle==1, go to S_CHECK.
  - S_CHECK: one cycle for inst_valid to settle on the held RPi_inst.
    - inst_valid==1: assert execute_task for exactly this cycle and go to S_WAIT_START.
    - inst_valid==0: set inst_reject, clear busy, go to S_IDLE.
  - S_WAIT_START: count cycles.
    - idle==0 observed at any count: clear busy, go to S_IDLE (accepted).
    - count reaches START_TIMEOUT with idle still 1: set inst_reject, clear busy, go to S_IDLE. This covers opcodes that pass the validity check but map to no task.
- RPi_inst stays stable from copy until the next good frame completes. It never changes while busy.
- cs_n fall while busy: the frame is clocked into the shadow but never copied. Set overrun at its cs_n rise. FSM progress is unaffected.
- A cs_n rise and a sclk rise in the same cycle: the sclk rise is processed first.
- execute_task is never asserted on two consecutive cycles. At most one execute_task per good frame.

Decomposition:
- Package rpi_link_pkg:
  - state enum: S_IDLE, S_RECV, S_WAIT_IDLE, S_CHECK, S_WAIT_START
  - INST_BYTES constant
  - status-bit index constants: ST_BUSY=7, ST_REJ=6, ST_FERR=5, ST_OVR=4
- One sub-module, rpi_sync_edge: SYNC_STAGES synchronizer plus rise and fall pulse outputs. Instantiated once each for sclk and cs_n; mosi uses the level output only.

Test Plan:
1. Frame FF 000000 000100 01FFFF with idle=1 and inst_valid=1 modelled; the model drops idle 2 cycles after execute_task -> RPi_inst=0xFF00000000010001FFFF, one execute_task pulse, busy falls, all flags 0.
2. 79-bit frame -> frame_err=1, RPi_inst unchanged, no execute_task. The next transfer's first MISO byte reads 0x20.
3. Good frame with inst_valid=0 -> inst_reject=1, no execute_task. Next status byte reads 0x40.
4. Good frame sent while idle=0 for 500 cycles -> execute_task is delayed until 1 cycle after idle returns; busy=1 throughout. A second frame during this window sets overrun and RPi_inst keeps the first frame.
5. Opcode 0xFE with idle held at 1 -> one execute_task pulse, then inst_reject=1 after 16 cycles, busy=0.
6. rst_n asserted after 40 of 80 bits, then a full good frame -> outputs return to reset values; the full frame is accepted normally.
